quad_speed_meter: RTL and testbench

// - N-channel quadrature-encoder speed meter: synchronises A/B inputs, decodes x4 Gray transitions into

---
 rtl/quad_pkg.sv | 27 ++
 rtl/quad_channel.sv | 92 +++++++++
 rtl/quad_speed_meter.sv | 106 ++++++++++
 tb/tb_quad_speed_meter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - step encoding and x4 Gray-code transition decoder for the quadrature speed meter
package quad_pkg;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ERR
    } step_e;

    // {A,B} forward order is 00 -> 10 -> 11 -> 01 -> 00; a two-bit change is undecodable
    function automatic step_e quad_decode(input logic [1:0] prev, input logic [1:0] cur);
        step_e s;
        if (prev == cur) begin
            s = STEP_NONE;
        end else if ((prev ^ cur) == 2'b11) begin
            s = STEP_ERR;
        end else begin
            case ({prev, cur})
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: s = STEP_FWD;
                default:                                s = STEP_REV;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/quad_channel.sv
// rtl/quad_channel.sv - one encoder channel: synchroniser, priming, decode, saturating window accumulator
module quad_channel
    import quad_pkg::*;
#(
    parameter int CNT_W       = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enc_a_i,
    input  logic               enc_b_i,
    input  logic               tick_i,
    input  logic               clear_i,
    output logic signed [CNT_W:0] sum_o,
    output logic               err_o,
    output logic               sat_o
);

    localparam int LIMIT_I = (1 << CNT_W) - 1;
    localparam logic signed [CNT_W+1:0] LIMIT = $signed((CNT_W + 2)'(LIMIT_I));

    logic [SYNC_STAGES-1:0][1:0] sync_q;
    logic [SYNC_STAGES-1:0]      fill_q;
    logic                        primed_q;
    logic [1:0]                  prev_q;
    logic signed [CNT_W:0]       acc_q, acc_d;
    logic                        err_q, err_d;
    logic                        sat_q, sat_d;

    logic [1:0]              cur;
    step_e                   step;
    logic signed [CNT_W+1:0] delta;
    logic signed [CNT_W+1:0] sum_w;
    logic signed [CNT_W+1:0] sum_c;
    logic                    hit;

    assign cur = sync_q[SYNC_STAGES-1];

    always_comb begin
        step  = primed_q ? quad_decode(prev_q, cur) : STEP_NONE;
        delta = '0;
        if (step == STEP_FWD) delta = (CNT_W + 2)'(1);
        if (step == STEP_REV) delta = '1;
        sum_w = $signed({acc_q[CNT_W], acc_q}) + delta;
        sum_c = sum_w;
        hit   = 1'b0;
        if (sum_w >= LIMIT) begin
            sum_c = LIMIT;
            hit   = 1'b1;
        end else if (sum_w <= -LIMIT) begin
            sum_c = -LIMIT;
            hit   = 1'b1;
        end
        sum_o = sum_c[CNT_W:0];
        err_o = err_q | (step == STEP_ERR);
        sat_o = sat_q | hit;

        // the closing window takes this cycle's step through sum_o, so the new one starts at zero
        acc_d = sum_o;
        err_d = err_o;
        sat_d = sat_o;
        if (tick_i || clear_i) begin
            acc_d = '0;
            err_d = 1'b0;
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            fill_q   <= '0;
            primed_q <= 1'b0;
            prev_q   <= '0;
            acc_q    <= '0;
            err_q    <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {enc_a_i, enc_b_i}};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            // prime only once the synchroniser holds a real pin sample, not its reset zeros
            if (primed_q || fill_q[SYNC_STAGES-1]) begin
                prev_q <= cur;
            end
            primed_q <= primed_q | fill_q[SYNC_STAGES-1];
            acc_q    <= acc_d;
            err_q    <= err_d;
            sat_q    <= sat_d;
        end
    end

endmodule

// File: rtl/quad_speed_meter.sv
// rtl/quad_speed_meter.sv - N-channel quadrature speed meter with fixed measurement window and publish registers
module quad_speed_meter
    import quad_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int CNT_W       = 15,
    parameter int WINDOW      = 5000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_CH-1:0]            enc_a,
    input  logic [N_CH-1:0]            enc_b,
    input  logic                       clear,
    output logic [N_CH*CNT_W-1:0]      speed,
    output logic [N_CH-1:0]            dir,
    output logic [N_CH-1:0]            err,
    output logic [N_CH-1:0]            sat,
    output logic [N_CH*(CNT_W+1)-1:0]  res,
    output logic                       res_valid
);

    localparam int CW = $clog2(WINDOW);

    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   tick;
    logic [N_CH*CNT_W-1:0]  speed_q, speed_d;
    logic [N_CH-1:0]        dir_q, dir_d;
    logic [N_CH-1:0]        err_q, err_d;
    logic [N_CH-1:0]        sat_q, sat_d;
    logic                   valid_q, valid_d;

    logic signed [CNT_W:0]  ch_sum [N_CH];
    logic [CNT_W:0]         mag    [N_CH];
    logic [N_CH-1:0]        ch_err;
    logic [N_CH-1:0]        ch_sat;

    assign tick = (cnt_q == CW'(WINDOW - 1));

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        quad_channel #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .enc_a_i (enc_a[g]),
            .enc_b_i (enc_b[g]),
            .tick_i  (tick),
            .clear_i (clear),
            .sum_o   (ch_sum[g]),
            .err_o   (ch_err[g]),
            .sat_o   (ch_sat[g])
        );

        assign mag[g] = ch_sum[g][CNT_W] ? -ch_sum[g] : ch_sum[g];
        // channel 0 lands in the most significant field
        assign res[(N_CH-1-g)*(CNT_W+1) +: (CNT_W+1)] = {dir_q[g], speed_q[g*CNT_W +: CNT_W]};
    end

    always_comb begin
        cnt_d   = (tick || clear) ? '0 : cnt_q + 1'b1;
        speed_d = speed_q;
        dir_d   = dir_q;
        err_d   = err_q;
        sat_d   = sat_q;
        valid_d = 1'b0;
        if (tick && !clear) begin
            for (int i = 0; i < N_CH; i++) begin
                speed_d[i*CNT_W +: CNT_W] = mag[i][CNT_W-1:0];
                // a zero net count keeps the last known direction
                if (ch_sum[i] != '0) begin
                    dir_d[i] = ~ch_sum[i][CNT_W];
                end
            end
            err_d   = ch_err;
            sat_d   = ch_sat;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            speed_q <= '0;
            dir_q   <= '0;
            err_q   <= '0;
            sat_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            speed_q <= speed_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
        end
    end

    assign speed     = speed_q;
    assign dir       = dir_q;
    assign err       = err_q;
    assign sat       = sat_q;
    assign res_valid = valid_q;

endmodule

// File: tb/tb_quad_speed_meter.sv
// tb/tb_quad_speed_meter.sv - self-checking bench for quad_speed_meter with window-aligned directed vectors
module tb_quad_speed_meter;

    localparam int WIN  = 100;
    localparam int NREC = 7;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  enc_a = 2'b00;
    logic [1:0]  enc_b = 2'b00;
    logic        clear = 1'b0;

    logic [29:0] speed;
    logic [1:0]  dir, err, sat;
    logic [31:0] res;
    logic        res_valid;

    logic [7:0]  speed_s;
    logic [1:0]  dir_s, err_s, sat_s;
    logic [9:0]  res_s;
    logic        res_valid_s;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    logic [1:0] p0 = 2'd0;
    logic [1:0] p1 = 2'd0;

    typedef struct {
        int f0; int r0; int i0;
        int f1; int r1; int i1;
        int sp0; int d0; int e0;
        int sp1; int d1; int e1;
        int sp0s; int st0s; int sp1s; int st1s;
    } rec_t;

    rec_t recs [NREC];

    quad_speed_meter #(.N_CH(2), .CNT_W(15), .WINDOW(WIN), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
        .speed(speed), .dir(dir), .err(err), .sat(sat), .res(res), .res_valid(res_valid)
    );

    quad_speed_meter #(.N_CH(2), .CNT_W(4), .WINDOW(WIN), .SYNC_STAGES(2)) dut_s (
        .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
        .speed(speed_s), .dir(dir_s), .err(err_s), .sat(sat_s), .res(res_s), .res_valid(res_valid_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    function automatic logic [1:0] gray(input logic [1:0] idx);
        case (idx)
            2'd0:    return 2'b00;
            2'd1:    return 2'b10;
            2'd2:    return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic drive();
        logic [1:0] g0, g1;
        g0 = gray(p0);
        g1 = gray(p1);
        enc_a = {g1[1], g0[1]};
        enc_b = {g1[0], g0[0]};
    endtask

    function automatic logic [1:0] move(input int i, input int f, input int r, input int il);
        if (i < f)          return 2'd1;
        if (i < f + r)      return 2'd3;
        if (i < f + r + il) return 2'd2;
        return 2'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check_rec(input int m, input rec_t r);
        logic [31:0] er;
        er = {r.d0[0], r.sp0[14:0], r.d1[0], r.sp1[14:0]};
        check($sformatf("w%0d res_valid", m), 32'(res_valid), 32'd1);
        check($sformatf("w%0d speed0", m), 32'(speed[14:0]), 32'(r.sp0));
        check($sformatf("w%0d speed1", m), 32'(speed[29:15]), 32'(r.sp1));
        check($sformatf("w%0d dir", m), 32'(dir), 32'({r.d1[0], r.d0[0]}));
        check($sformatf("w%0d err", m), 32'(err), 32'({r.e1[0], r.e0[0]}));
        check($sformatf("w%0d sat", m), 32'(sat), 32'd0);
        check($sformatf("w%0d res", m), res, er);
        check($sformatf("w%0d small speed0", m), 32'(speed_s[3:0]), 32'(r.sp0s));
        check($sformatf("w%0d small speed1", m), 32'(speed_s[7:4]), 32'(r.sp1s));
        check($sformatf("w%0d small sat", m), 32'(sat_s), 32'({r.st1s[0], r.st0s[0]}));
        check($sformatf("w%0d small dir", m), 32'(dir_s), 32'({r.d1[0], r.d0[0]}));
    endtask

    initial begin
        recs[0] = '{0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0,   0, 0,  0, 0};
        recs[1] = '{100, 0, 0, 0, 0, 0, 100, 1, 0, 0, 0, 0,  15, 1,  0, 0};
        recs[2] = '{0, 0, 0, 10, 30, 0, 0, 1, 0,  20, 0, 0,   0, 0, 15, 1};
        recs[3] = '{0, 0, 0, 0, 0, 0,   0, 1, 0,  0, 0, 0,   0, 0,  0, 0};
        recs[4] = '{3, 0, 1, 0, 0, 0,   3, 1, 1,  0, 0, 0,   3, 0,  0, 0};
        recs[5] = '{0, 0, 0, 0, 0, 0,   0, 1, 0,  0, 0, 0,   0, 0,  0, 0};
        recs[6] = '{0, 5, 0, 7, 0, 0,   5, 0, 0,  7, 1, 0,   5, 0,  7, 0};

        // ch0 parked at {A,B}=11 through reset to exercise priming
        p0 = 2'd2;
        p1 = 2'd0;
        drive();
        repeat (3) @(negedge clk);
        check("reset speed", 32'(speed), 32'd0);
        check("reset res", res, 32'd0);
        check("reset flags", 32'({dir, err, sat, res_valid}), 32'd0);
        reset_n = 1'b1;

        for (int m = 1; m < NREC; m++) begin
            for (int s = WIN * m - 2; s < WIN * m + WIN - 2; s++) begin
                int i;
                wait_neg(s);
                if (s == WIN * m - 1) check($sformatf("w%0d early res_valid", m - 1), 32'(res_valid), 32'd0);
                if (s == WIN * m) check_rec(m - 1, recs[m - 1]);
                i = s - (WIN * m - 2);
                p0 = p0 + move(i, recs[m].f0, recs[m].r0, recs[m].i0);
                p1 = p1 + move(i, recs[m].f1, recs[m].r1, recs[m].i1);
                drive();
            end
        end
        wait_neg(WIN * NREC - 1);
        check("w6 early res_valid", 32'(res_valid), 32'd0);
        wait_neg(WIN * NREC);
        check_rec(NREC - 1, recs[NREC - 1]);

        // step decoded on the tick cycle closes with window 7, the next one opens window 8
        wait_neg(797); p0 = p0 + 2'd1; drive();
        wait_neg(798); p0 = p0 + 2'd1; drive();
        wait_neg(800);
        check("tick step rv", 32'(res_valid), 32'd1);
        check("tick step speed0", 32'(speed[14:0]), 32'd1);
        check("tick step dir", 32'(dir), 32'd3);
        check("idle speed1", 32'(speed[29:15]), 32'd0);
        wait_neg(900);
        check("post tick rv", 32'(res_valid), 32'd1);
        check("post tick speed0", 32'(speed[14:0]), 32'd1);
        p0 = p0 + 2'd1; drive();
        wait_neg(901); p0 = p0 + 2'd1; drive();

        // clear during the tick cycle suppresses the publish and restarts the window
        wait_neg(999); clear = 1'b1;
        wait_neg(1000); clear = 1'b0;
        check("clear at tick rv", 32'(res_valid), 32'd0);
        check("clear holds speed0", 32'(speed[14:0]), 32'd1);
        wait_neg(1099);
        check("after clear early rv", 32'(res_valid), 32'd0);
        wait_neg(1100);
        check("after clear rv", 32'(res_valid), 32'd1);
        check("after clear speed0", 32'(speed[14:0]), 32'd0);
        check("after clear dir0", 32'(dir[0]), 32'd1);

        // reset mid-window, then re-prime with ch0 sitting at a non-zero Gray state
        wait_neg(1150);
        reset_n = 1'b0;
        #1;
        check("midreset speed", 32'(speed), 32'd0);
        check("midreset flags", 32'({dir, err, sat, res_valid}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_neg(WIN);
        check("reprime rv", 32'(res_valid), 32'd1);
        check("reprime err", 32'(err), 32'd0);
        check("reprime speed", 32'(speed), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
